// File: rtl/goertzel_pkg.sv
// Shared constants and FSM encoding for the Goertzel datapath.
// The loop core imports this too, so the sample width and the coefficient
// format stay identical on both sides.
package goertzel_pkg;

    localparam int unsigned GZ_D_W  = 16;   // T1/T2/coeff width
    localparam int unsigned GZ_FRAC = 14;   // coeff is Q2.14
    localparam int unsigned MAG_W   = 32;   // magnitude / threshold width
    localparam int unsigned ACC_W   = 35;   // signed magnitude accumulator

    localparam logic [MAG_W-1:0] MAG_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CAP   = 3'd1,
        ST_SQ1   = 3'd2,
        ST_SQ2   = 3'd3,
        ST_CT1   = 3'd4,
        ST_CROSS = 3'd5,
        ST_FINAL = 3'd6
    } gz_state_e;

endpackage

// File: rtl/goertzel_mag_detect_if.sv
// Request/result bundle between the loop core / control logic and the
// magnitude detector.
//   master: drives start, T1, T2, coeff, thresh; reads the results.
//   slave : the detector; drives busy, mag, mag_valid, detect, overrun.
interface goertzel_mag_detect_if #(
    parameter int unsigned D_W = 16,
    parameter int unsigned M_W = 32
);
    logic                  start;
    logic signed [D_W-1:0] T1;
    logic signed [D_W-1:0] T2;
    logic signed [D_W-1:0] coeff;
    logic [M_W-1:0]        thresh;
    logic                  busy;
    logic [M_W-1:0]        mag;
    logic                  mag_valid;
    logic                  detect;
    logic                  overrun;

    modport master (
        output start, T1, T2, coeff, thresh,
        input  busy, mag, mag_valid, detect, overrun
    );

    modport slave (
        input  start, T1, T2, coeff, thresh,
        output busy, mag, mag_valid, detect, overrun
    );
endinterface

// File: rtl/gz_mag_mul.sv
// Registered signed A_W x B_W multiplier with clock enable (one MAC16 tile).
//   sys_clk, rst_n : clock, synchronous active-low reset
//   ce             : load a new product
//   a, b           : signed operands
//   p              : registered signed product, one cycle after ce
module gz_mag_mul #(
    parameter int unsigned A_W = 18,
    parameter int unsigned B_W = 16
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    output logic signed [A_W+B_W-1:0] p
);
    localparam int unsigned P_W = A_W + B_W;

    logic signed [P_W-1:0] p_q;
    logic signed [P_W-1:0] p_d;

    always_comb begin
        p_d = p_q;
        if (ce) begin
            p_d = P_W'(a) * P_W'(b);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/goertzel_mag_detect.sv
// Goertzel squared-magnitude and debounced tone detector.
// On start it captures T1/T2/coeff/thresh, computes
// P = T1^2 + T2^2 - coeff*T1*T2 with one shared multiplier over six cycles,
// clamps P into M_W bits and debounces (P >= thresh) across frames.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   bus (slave)    : start/T1/T2/coeff/thresh in;
//                    busy/mag/mag_valid/detect/overrun out
module goertzel_mag_detect
    import goertzel_pkg::*;
#(
    parameter int unsigned D_W    = GZ_D_W,
    parameter int unsigned FRAC   = GZ_FRAC,
    parameter int unsigned M_W    = MAG_W,
    parameter int unsigned HOLD_N = 3
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    goertzel_mag_detect_if.slave bus
);
    localparam int unsigned A_W   = D_W + 2;   // widened for the Q-shifted cross operand
    localparam int unsigned P_W   = A_W + D_W;
    localparam int unsigned CNT_W = 4;

    gz_state_e               state_q, state_d;
    logic signed [D_W-1:0]   t1_q, t1_d;
    logic signed [D_W-1:0]   t2_q, t2_d;
    logic signed [D_W-1:0]   coeff_q, coeff_d;
    logic [M_W-1:0]          thresh_q, thresh_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [M_W-1:0]          mag_q, mag_d;
    logic                    mag_valid_q, mag_valid_d;
    logic                    detect_q, detect_d;
    logic                    overrun_q, overrun_d;
    logic                    busy_q, busy_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    mul_ce;
    logic signed [A_W-1:0]   mul_a;
    logic signed [D_W-1:0]   mul_b;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_fin;
    logic [M_W-1:0]          mag_new;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    hit;
    logic                    step;

    // Operand mux for the shared multiplier; CROSS reuses coeff*T1 >>> FRAC.
    always_comb begin
        mul_ce = 1'b0;
        mul_a  = '0;
        mul_b  = '0;
        unique case (state_q)
            ST_SQ1: begin
                mul_ce = 1'b1;
                mul_a  = A_W'(t1_q);
                mul_b  = t1_q;
            end
            ST_SQ2: begin
                mul_ce = 1'b1;
                mul_a  = A_W'(t2_q);
                mul_b  = t2_q;
            end
            ST_CT1: begin
                mul_ce = 1'b1;
                mul_a  = A_W'(coeff_q);
                mul_b  = t1_q;
            end
            ST_CROSS: begin
                mul_ce = 1'b1;
                mul_a  = prod[FRAC+A_W-1:FRAC];
                mul_b  = t2_q;
            end
            default: ;
        endcase
    end

    gz_mag_mul #(
        .A_W (A_W),
        .B_W (D_W)
    ) u_mul (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .ce      (mul_ce),
        .a       (mul_a),
        .b       (mul_b),
        .p       (prod)
    );

    // Final magnitude: clamp negatives to 0, saturate above M_W bits.
    always_comb begin
        prod_ext = ACC_W'(prod);
        acc_fin  = acc_q - prod_ext;
        if (acc_fin[ACC_W-1]) begin
            mag_new = '0;
        end else if (|acc_fin[ACC_W-2:M_W]) begin
            mag_new = '1;
        end else begin
            mag_new = acc_fin[M_W-1:0];
        end
        hit     = (mag_new >= thresh_q);
        step    = detect_q ? !hit : hit;
        cnt_inc = cnt_q + CNT_W'(1);
    end

    // Next-state, datapath and debounce.
    always_comb begin
        state_d     = state_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        coeff_d     = coeff_q;
        thresh_d    = thresh_q;
        acc_d       = acc_q;
        mag_d       = mag_q;
        mag_valid_d = 1'b0;
        detect_d    = detect_q;
        cnt_d       = cnt_q;
        overrun_d   = bus.start && (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    t1_d     = bus.T1;
                    t2_d     = bus.T2;
                    coeff_d  = bus.coeff;
                    thresh_d = bus.thresh;
                    state_d  = ST_CAP;
                end
            end
            ST_CAP: begin
                acc_d   = '0;
                state_d = ST_SQ1;
            end
            ST_SQ1: state_d = ST_SQ2;
            ST_SQ2: begin
                acc_d   = acc_q + prod_ext;   // T1^2
                state_d = ST_CT1;
            end
            ST_CT1: begin
                acc_d   = acc_q + prod_ext;   // T2^2
                state_d = ST_CROSS;
            end
            ST_CROSS: state_d = ST_FINAL;
            ST_FINAL: begin
                acc_d       = acc_fin;
                mag_d       = mag_new;
                mag_valid_d = 1'b1;
                // Count frames that disagree with detect; flip after HOLD_N in a row.
                if (step) begin
                    if (cnt_inc >= CNT_W'(HOLD_N)) begin
                        detect_d = !detect_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            t1_q        <= '0;
            t2_q        <= '0;
            coeff_q     <= '0;
            thresh_q    <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            mag_valid_q <= 1'b0;
            detect_q    <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            coeff_q     <= coeff_d;
            thresh_q    <= thresh_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            mag_valid_q <= mag_valid_d;
            detect_q    <= detect_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mag       = mag_q;
    assign bus.mag_valid = mag_valid_q;
    assign bus.detect    = detect_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_goertzel_mag_detect.sv
// Scoreboard bench for goertzel_mag_detect: frames push expected
// {mag, detect, arrival cycle}; a monitor pops on every mag_valid.
module tb_goertzel_mag_detect;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    int unsigned cyc     = 0;
    int unsigned total   = 0;
    int unsigned bad     = 0;

    typedef struct {
        logic [31:0] mag;
        logic        det;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    goertzel_mag_detect_if #(.D_W(16), .M_W(32)) gif ();

    goertzel_mag_detect #(
        .D_W    (16),
        .FRAC   (14),
        .M_W    (32),
        .HOLD_N (3)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (gif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every mag_valid must match the oldest expected frame.
    always @(negedge sys_clk) begin
        if (gif.mag_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'(gif.mag), 64'hdead);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mag", 64'(gif.mag), 64'(e.mag));
                chk("detect", 64'(gif.detect), 64'(e.det));
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drive_start(input logic signed [15:0] t1, input logic signed [15:0] t2,
                               input logic signed [15:0] c, input logic [31:0] th);
        gif.start  = 1'b1;
        gif.T1     = t1;
        gif.T2     = t2;
        gif.coeff  = c;
        gif.thresh = th;
    endtask

    // One full frame (8 cycles); inputs are scrambled after capture.
    task automatic run_frame(input logic signed [15:0] t1, input logic signed [15:0] t2,
                             input logic signed [15:0] c, input logic [31:0] th,
                             input logic [31:0] exp_mag, input logic exp_det);
        exp_t e;
        int   busy_cnt;
        e.mag = exp_mag;
        e.det = exp_det;
        e.cyc = cyc + 7;
        sb.push_back(e);
        drive_start(t1, t2, c, th);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            gif.start  = 1'b0;
            gif.T1     = 16'($urandom);
            gif.T2     = 16'($urandom);
            gif.coeff  = 16'($urandom);
            gif.thresh = $urandom;
            if (gif.busy === 1'b1) busy_cnt++;
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd6);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (5000) @(posedge sys_clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gif.start  = 1'b0;
        gif.T1     = '0;
        gif.T2     = '0;
        gif.coeff  = '0;
        gif.thresh = '0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;

        chk("rst_busy", 64'(gif.busy), 64'd0);
        chk("rst_mag", 64'(gif.mag), 64'd0);
        chk("rst_mag_valid", 64'(gif.mag_valid), 64'd0);
        chk("rst_detect", 64'(gif.detect), 64'd0);
        chk("rst_overrun", 64'(gif.overrun), 64'd0);

        // Basic magnitudes
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b0);
        run_frame(16'sd100, 16'sd100, 16'sd16384, 32'hFFFF_FFFF, 32'd10000, 1'b0);
        run_frame(-16'sd100, -16'sd100, 16'sd16384, 32'hFFFF_FFFF, 32'd10000, 1'b0);
        run_frame(16'sh8000, 16'sh8000, 16'sh8000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mag_hold", 64'(gif.mag), 64'hFFFF_FFFF);

        // Debounce from a clean counter
        pulse_reset();
        chk("rst2_mag", 64'(gif.mag), 64'd0);
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b0);
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b0);
        run_frame(16'sd0,   16'sd0, 16'sd0, 32'd5000, 32'd0,     1'b0);
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b0);
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b0);
        run_frame(16'sd100, 16'sd0, 16'sd0, 32'd5000, 32'd10000, 1'b1);
        run_frame(16'sd0,   16'sd0, 16'sd0, 32'd5000, 32'd0,     1'b1);
        run_frame(16'sd0,   16'sd0, 16'sd0, 32'd5000, 32'd0,     1'b1);
        run_frame(16'sd0,   16'sd0, 16'sd0, 32'd5000, 32'd0,     1'b0);

        // Overrun: second start two cycles in, then one on the busy-fall cycle
        begin
            exp_t e;
            e.mag = 32'd10000;
            e.det = 1'b0;
            e.cyc = cyc + 7;
            sb.push_back(e);
        end
        drive_start(16'sd100, 16'sd0, 16'sd0, 32'd5000);
        @(negedge sys_clk);
        gif.start = 1'b0;
        chk("ovr_idle", 64'(gif.overrun), 64'd0);
        @(negedge sys_clk);
        drive_start(16'sd50, 16'sd50, 16'sd1, 32'd0);
        @(negedge sys_clk);
        gif.start = 1'b0;
        chk("ovr_pulse", 64'(gif.overrun), 64'd1);
        @(negedge sys_clk);
        chk("ovr_one_cycle", 64'(gif.overrun), 64'd0);
        repeat (2) @(negedge sys_clk);
        chk("busy_in_final", 64'(gif.busy), 64'd1);
        drive_start(16'sd7, 16'sd7, 16'sd0, 32'd0);
        @(negedge sys_clk);
        gif.start = 1'b0;
        chk("ovr_at_fall", 64'(gif.overrun), 64'd1);
        chk("busy_fell", 64'(gif.busy), 64'd0);
        repeat (8) @(negedge sys_clk);
        chk("ovr_mag_kept", 64'(gif.mag), 64'd10000);

        // Reset during SQ2 aborts the frame
        drive_start(16'sd100, 16'sd0, 16'sd0, 32'd5000);
        @(negedge sys_clk);
        gif.start = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        chk("abort_mag", 64'(gif.mag), 64'd0);
        chk("abort_busy", 64'(gif.busy), 64'd0);
        chk("abort_detect", 64'(gif.detect), 64'd0);
        repeat (8) @(negedge sys_clk);
        run_frame(16'sd100, 16'sd100, 16'sd16384, 32'd5000, 32'd10000, 1'b0);

        repeat (4) @(negedge sys_clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
